// File: rtl/mig_ui_pkg.sv
// rtl/mig_ui_pkg.sv - shared command codes and queue entry types for the MIG UI model
package mig_ui_pkg;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  // Entry types are fixed-width; the model's DATA_W must equal LINE_DATA_W.
  localparam int LINE_DATA_W = 128;
  localparam int LINE_IDX_W  = 32;

  typedef struct packed {
    logic                  is_read;
    logic [LINE_IDX_W-1:0] idx;
  } cmd_entry_t;

  typedef struct packed {
    logic [LINE_DATA_W/8-1:0] mask;
    logic [LINE_DATA_W-1:0]   data;
  } wdf_entry_t;

  function automatic logic cmd_legal(input logic [2:0] cmd);
    return (cmd == MIG_CMD_WRITE) || (cmd == MIG_CMD_READ);
  endfunction

endpackage

// File: rtl/mig_ui_model_if.sv
// rtl/mig_ui_model_if.sv - MIG 7-series app_* user interface bundle
interface mig_ui_model_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic                app_wdf_rdy;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;
  logic                app_rd_data_end;
  logic                init_calib_complete;
  logic                err_illegal_cmd;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, err_illegal_cmd
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, err_illegal_cmd
  );
endinterface

// File: rtl/mig_ui_fifo.sv
// rtl/mig_ui_fifo.sv - first-word-fall-through sync FIFO used for the command and write-data queues
module mig_ui_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] store [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = store[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) store[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mig_ui_model.sv
// rtl/mig_ui_model.sv - cycle-level MIG UI responder backed by an internal line memory
module mig_ui_model
  import mig_ui_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = LINE_DATA_W,
  parameter int MEM_LINES   = 4096,
  parameter int RD_LATENCY  = 8,
  parameter int CALIB_CYC   = 64,
  parameter int Q_DEPTH     = 4,
  parameter int STALL_EVERY = 0
) (
  input  logic            clk_core,
  input  logic            reset,
  mig_ui_model_if.slave   ui
);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CAL_W = $clog2(CALIB_CYC + 1);

  logic             calib;
  logic [CAL_W-1:0] cal_cnt;
  logic             throttle;
  logic             app_rdy;
  logic             wdf_rdy;
  logic             cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic             wdf_full, wdf_empty, wdf_push, wdf_pop;
  cmd_entry_t       cmd_in, cmd_head;
  wdf_entry_t       wdf_in, wdf_head;
  logic             exec_rd, exec_wr;
  logic [IDX_W-1:0] head_idx;
  logic [DATA_W-1:0] rd_line;
  logic             err;

  logic [DATA_W-1:0]     mem [MEM_LINES];
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [DATA_W-1:0]     dat_pipe [RD_LATENCY];

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      calib   <= 1'b0;
      cal_cnt <= '0;
    end else if (!calib) begin
      if (cal_cnt == CAL_W'(CALIB_CYC - 1)) calib <= 1'b1;
      cal_cnt <= cal_cnt + CAL_W'(1);
    end
  end

  generate
    if (STALL_EVERY > 0) begin : g_thr
      localparam int THR_W = $clog2(STALL_EVERY + 1);
      logic [THR_W-1:0] thr_cnt;
      always_ff @(posedge clk_core or posedge reset) begin
        if (reset) thr_cnt <= '0;
        else if (calib) thr_cnt <= (thr_cnt == THR_W'(STALL_EVERY - 1)) ? '0 : thr_cnt + THR_W'(1);
      end
      assign throttle = calib && (thr_cnt == THR_W'(STALL_EVERY - 1));
    end else begin : g_nothr
      assign throttle = 1'b0;
    end
  endgenerate

  // Ready depends only on registered state so initiators may sample it before driving en.
  assign app_rdy = calib && !cmd_full && !throttle;
  assign wdf_rdy = calib && !wdf_full;

  assign cmd_push = ui.app_en && app_rdy && cmd_legal(ui.app_cmd);
  assign wdf_push = ui.app_wdf_wren && wdf_rdy;

  always_comb begin
    cmd_in         = '0;
    cmd_in.is_read = (ui.app_cmd == MIG_CMD_READ);
    cmd_in.idx     = LINE_IDX_W'(ui.app_addr[3 +: IDX_W]);
    wdf_in         = '0;
    wdf_in.mask    = ui.app_wdf_mask;
    wdf_in.data    = ui.app_wdf_data;
  end

  mig_ui_fifo #(.W($bits(cmd_entry_t)), .DEPTH(Q_DEPTH)) u_cmdq (
    .clk(clk_core), .rst(reset), .push(cmd_push), .push_data(cmd_in),
    .pop(cmd_pop), .pop_data(cmd_head), .full(cmd_full), .empty(cmd_empty)
  );

  mig_ui_fifo #(.W($bits(wdf_entry_t)), .DEPTH(Q_DEPTH)) u_wdfq (
    .clk(clk_core), .rst(reset), .push(wdf_push), .push_data(wdf_in),
    .pop(wdf_pop), .pop_data(wdf_head), .full(wdf_full), .empty(wdf_empty)
  );

  // A write at the head waits for its data; nothing behind it may overtake.
  assign exec_rd  = !cmd_empty && cmd_head.is_read;
  assign exec_wr  = !cmd_empty && !cmd_head.is_read && !wdf_empty;
  assign cmd_pop  = exec_rd || exec_wr;
  assign wdf_pop  = exec_wr;
  assign head_idx = cmd_head.idx[IDX_W-1:0];
  assign rd_line  = mem[head_idx];

  always_ff @(posedge clk_core) begin
    if (exec_wr) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (!wdf_head.mask[b]) mem[head_idx][b*8 +: 8] <= wdf_head.data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= exec_rd;
      if (exec_rd) dat_pipe[0] <= rd_line;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) err <= 1'b0;
    else if ((ui.app_en && app_rdy && !cmd_legal(ui.app_cmd)) ||
             (wdf_push && !ui.app_wdf_end)) err <= 1'b1;
  end

  assign ui.app_rdy             = app_rdy;
  assign ui.app_wdf_rdy         = wdf_rdy;
  assign ui.app_rd_data         = dat_pipe[RD_LATENCY-1];
  assign ui.app_rd_data_valid   = vld_pipe[RD_LATENCY-1];
  assign ui.app_rd_data_end     = vld_pipe[RD_LATENCY-1];
  assign ui.init_calib_complete = calib;
  assign ui.err_illegal_cmd     = err;

  // Address bits outside the line index alias; the head index is wider than the array needs.
  logic [ADDR_W-1:0] addr_unused;
  logic              sink_unused;
  assign addr_unused = ui.app_addr;
  assign sink_unused = &{1'b0, addr_unused, cmd_head.idx};

endmodule

// File: tb/tb_mig_ui_model.sv
// tb/tb_mig_ui_model.sv - scoreboard bench for mig_ui_model
module tb_mig_ui_model;
  import mig_ui_pkg::*;

  logic clk_core = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  mig_ui_model_if #(.ADDR_W(28), .DATA_W(128)) bus ();
  mig_ui_model_if #(.ADDR_W(28), .DATA_W(128)) bus2 ();

  mig_ui_model dut (.clk_core(clk_core), .reset(rst), .ui(bus));
  mig_ui_model #(.CALIB_CYC(8), .STALL_EVERY(3)) dut2 (.clk_core(clk_core), .reset(rst2), .ui(bus2));

  typedef struct { logic [127:0] data; int due; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0, rx_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  always @(negedge clk_core) begin
    if (!rst && bus.app_rd_data_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", bus.app_rd_data_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", bus.app_rd_data, e.data);
        check("rd_end", bus.app_rd_data_end, 1'b1);
        if (e.due >= 0) check("rd_latency", cyc, e.due);
      end
    end
  end

  task automatic do_cmd(input logic [2:0] c, input logic [27:0] a, output int acc);
    int n = 0;
    bus.app_en = 1'b1; bus.app_cmd = c; bus.app_addr = a;
    while (!bus.app_rdy && n < 200) begin @(negedge clk_core); n++; end
    if (n >= 200) check("cmd_accept_timeout", bus.app_rdy, 1'b1);
    @(posedge clk_core); #1;
    acc = cyc;
    bus.app_en = 1'b0;
    @(negedge clk_core);
  endtask

  task automatic do_wdf(input logic [127:0] d, input logic [15:0] m);
    int n = 0;
    bus.app_wdf_wren = 1'b1; bus.app_wdf_end = 1'b1; bus.app_wdf_data = d; bus.app_wdf_mask = m;
    while (!bus.app_wdf_rdy && n < 200) begin @(negedge clk_core); n++; end
    if (n >= 200) check("wdf_accept_timeout", bus.app_wdf_rdy, 1'b1);
    @(posedge clk_core); #1;
    bus.app_wdf_wren = 1'b0; bus.app_wdf_end = 1'b0;
    @(negedge clk_core);
  endtask

  task automatic write_both(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    int n = 0;
    bus.app_en = 1'b1; bus.app_cmd = MIG_CMD_WRITE; bus.app_addr = a;
    bus.app_wdf_wren = 1'b1; bus.app_wdf_end = 1'b1; bus.app_wdf_data = d; bus.app_wdf_mask = m;
    while (!(bus.app_rdy && bus.app_wdf_rdy) && n < 200) begin @(negedge clk_core); n++; end
    if (n >= 200) check("write_accept_timeout", bus.app_rdy, 1'b1);
    @(posedge clk_core); #1;
    bus.app_en = 1'b0; bus.app_wdf_wren = 1'b0; bus.app_wdf_end = 1'b0;
    @(negedge clk_core);
  endtask

  task automatic read_exp(input logic [27:0] a, input logic [127:0] d, input bit lat);
    int acc;
    exp_t e;
    do_cmd(MIG_CMD_READ, a, acc);
    e.data = d;
    e.due  = lat ? acc + 8 : -1;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(negedge clk_core); n++; end
    check(name, exp_q.size(), 0);
  endtask

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hCAFEF00D_DEADBEEF_13579BDF_2468ACE0;
  localparam logic [127:0] D3 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] MERGED = {{8{8'hAA}}, {8{8'h55}}};

  initial begin
    int n, acc, r0, vseen;
    bit saw_rdy;
    bus.app_en = 0; bus.app_cmd = 0; bus.app_addr = 0;
    bus.app_wdf_wren = 0; bus.app_wdf_end = 0; bus.app_wdf_data = 0; bus.app_wdf_mask = 0;
    bus2.app_en = 0; bus2.app_cmd = 0; bus2.app_addr = 0;
    bus2.app_wdf_wren = 0; bus2.app_wdf_end = 0; bus2.app_wdf_data = 0; bus2.app_wdf_mask = 0;

    repeat (3) @(negedge clk_core);
    check("rst_app_rdy", bus.app_rdy, 1'b0);
    check("rst_wdf_rdy", bus.app_wdf_rdy, 1'b0);
    check("rst_rd_valid", bus.app_rd_data_valid, 1'b0);
    check("rst_rd_data", bus.app_rd_data, '0);
    check("rst_calib", bus.init_calib_complete, 1'b0);
    check("rst_err", bus.err_illegal_cmd, 1'b0);

    rst = 1'b0;
    n = 0; saw_rdy = 0;
    while (!bus.init_calib_complete && n < 200) begin
      if (bus.app_rdy || bus.app_wdf_rdy) saw_rdy = 1;
      @(negedge clk_core); n++;
    end
    check("calib_cycles", n, 64);
    check("rdy_before_calib", saw_rdy, 1'b0);
    check("app_rdy_after_calib", bus.app_rdy, 1'b1);
    check("wdf_rdy_after_calib", bus.app_wdf_rdy, 1'b1);

    // write then read, read-after-write and write-after-read on the same line
    write_both(28'h10, D1, 16'h0000);
    read_exp(28'h10, D1, 1);
    write_both(28'h10, D2, 16'h0000);
    read_exp(28'h10, D2, 1);
    drain("drain_raw");

    // masked merge over a preloaded line
    write_both(28'h28, {16{8'hAA}}, 16'h0000);
    write_both(28'h28, {16{8'h55}}, 16'hFF00);
    read_exp(28'h28, MERGED, 1);
    drain("drain_mask");
    check("mem_line5", dut.mem[5], MERGED);

    // write command waits for its data and blocks the read behind it
    do_cmd(MIG_CMD_WRITE, 28'h40, acc);
    repeat (5) @(negedge clk_core);
    r0 = rx_cnt;
    read_exp(28'h40, D3, 0);
    repeat (12) @(negedge clk_core);
    check("stall_no_rd", rx_cnt, r0);
    do_wdf(D3, 16'h0000);
    drain("drain_stall");

    // four data-less writes fill the command queue
    for (int k = 0; k < 4; k++) do_cmd(MIG_CMD_WRITE, 28'h80 + 28'(8*k), acc);
    check("cmdq_full_rdy", bus.app_rdy, 1'b0);
    check("wdfq_rdy_while_cmdq_full", bus.app_wdf_rdy, 1'b1);
    for (int k = 0; k < 4; k++) do_wdf({4{32'hC0DE0000 + k}}, 16'h0000);
    read_exp(28'h80, {4{32'hC0DE0000}}, 0);
    read_exp(28'h98, {4{32'hC0DE0003}}, 0);
    drain("drain_full");

    // illegal command sets the sticky flag and returns nothing
    check("err_before_illegal", bus.err_illegal_cmd, 1'b0);
    r0 = rx_cnt;
    do_cmd(3'b010, 28'h10, acc);
    check("err_illegal", bus.err_illegal_cmd, 1'b1);
    repeat (12) @(negedge clk_core);
    check("illegal_no_rd", rx_cnt, r0);

    // reset with reads in flight discards them
    for (int k = 0; k < 3; k++) do_cmd(MIG_CMD_READ, 28'h10, acc);
    repeat (2) @(negedge clk_core);
    rst = 1'b1;
    repeat (2) @(negedge clk_core);
    check("midrst_rd_valid", bus.app_rd_data_valid, 1'b0);
    check("midrst_err_cleared", bus.err_illegal_cmd, 1'b0);
    rst = 1'b0;
    vseen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_core);
      if (bus.app_rd_data_valid) vseen++;
    end
    check("post_reset_no_rd", vseen, 0);
    check("post_reset_recalib", bus.app_rdy, 1'b0);

    // throttled instance: app_rdy low every third cycle from calibration
    rst2 = 1'b0;
    n = 0;
    while (!bus2.init_calib_complete && n < 50) begin @(negedge clk_core); n++; end
    check("calib2_cycles", n, 8);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("throttle_%0d", k), bus2.app_rdy, ((k % 3) != 2));
      @(negedge clk_core);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
